// File: rtl/wb_regfile.sv
// Writeback stage and integer register file.
// The WB mux feeds the array, the EX forwarding tap and, optionally, the decode
// read ports. Reads are combinational. x0 is hardwired to zero.
// The retire counter counts every valid WB instruction.
// Build option: define REGFILE_BYPASS_EN to get write-first reads.
// A decode read of the register being written this cycle then returns the new value.
// When it is undefined, the read returns the old array contents.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [XLEN-1:0]   mem_data_in,
  input  logic [XLEN-1:0]   ex_result_in,
  input  logic [AW-1:0]     rd_in,
  input  logic              werf_in,
  input  logic              wb_sel_in,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              fwd_en,
  output logic [AW-1:0]     fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  instret
);

  logic [XLEN-1:0]  wb_data;
  logic             we;
  logic [XLEN-1:0]  rf_q [NREGS];
  logic [CNT_W-1:0] instret_reg;

  assign wb_data = wb_sel_in ? mem_data_in : ex_result_in;
  // A write to x0 is not a write at all, so it is also never forwarded.
  assign we      = wb_valid & werf_in & (rd_in != '0);

  // x0 has no storage.
  assign rf_q[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] q_reg;

      // Each architectural register: reset clears it, and reset beats a write in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (we && (rd_in == AW'(gi))) begin
          q_reg <= wb_data;
        end
      end

      assign rf_q[gi] = q_reg;
    end
  endgenerate

  // Decode read port 1: array value, or optionally the value being written this cycle.
  always_comb begin
    rs1_data = rf_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
    if (we && (rs1_addr == rd_in)) begin
      rs1_data = wb_data;
    end
`endif
  end

  // Decode read port 2: same as port 1.
  always_comb begin
    rs2_data = rf_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (we && (rs2_addr == rd_in)) begin
      rs2_data = wb_data;
    end
`endif
  end

  // The forwarding tap is unqualified apart from fwd_en; consumers must gate on it.
  assign fwd_en   = we;
  assign fwd_rd   = rd_in;
  assign fwd_data = wb_data;

  // Retire counter: counts every valid WB slot, whether or not it writes, and wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (wb_valid) begin
      instret_reg <= instret_reg + 1'b1;
    end
  end

  assign instret = instret_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile.
// A behavioural register-file model is checked against the DUT on every negedge.
// Directed test-plan sequences add literal checks, and randomized traffic follows them.
// The expectations follow REGFILE_BYPASS_EN the same way the DUT build does.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] mem_data_in;
  logic [31:0] ex_result_in;
  logic [4:0]  rd_in;
  logic        werf_in;
  logic        wb_sel_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .mem_data_in(mem_data_in),
    .ex_result_in(ex_result_in), .rd_in(rd_in), .werf_in(werf_in),
    .wb_sel_in(wb_sel_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_en(fwd_en),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference state.
  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;
  bit          m_known = 1'b0;

  function automatic logic m_we();
    return wb_valid && werf_in && (rd_in != 5'd0);
  endfunction

  function automatic logic [31:0] m_wbdata();
    return wb_sel_in ? mem_data_in : ex_result_in;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (m_we() && a == rd_in) return m_wbdata();
`endif
    return m_regs[a];
  endfunction

  // Compare the outputs mid-cycle, then advance the model on the rising edge.
  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 64'd0;
    while (!done) begin
      @(negedge clk);
      if (m_known) begin
        check("rs1_data", {32'd0, rs1_data}, {32'd0, m_read(rs1_addr)});
        check("rs2_data", {32'd0, rs2_data}, {32'd0, m_read(rs2_addr)});
        check("fwd_en",   {63'd0, fwd_en},   {63'd0, m_we()});
        check("fwd_rd",   {59'd0, fwd_rd},   {59'd0, rd_in});
        check("fwd_data", {32'd0, fwd_data}, {32'd0, m_wbdata()});
        check("instret",  instret,           m_cnt);
      end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt   = 64'd0;
        m_known = 1'b1;
      end else begin
        if (m_we()) m_regs[rd_in] = m_wbdata();
        if (wb_valid) m_cnt = m_cnt + 64'd1;
      end
    end
  end

  task automatic apply(input logic r, input logic v, input logic w, input logic [4:0] rd,
                       input logic sel, input logic [31:0] mem, input logic [31:0] ex,
                       input logic [4:0] a1, input logic [4:0] a2);
    rst = r; wb_valid = v; werf_in = w; rd_in = rd; wb_sel_in = sel;
    mem_data_in = mem; ex_result_in = ex; rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5, 0);
    check("post_reset_x5", {32'd0, rs1_data}, 64'h0);
    check("post_reset_instret", instret, 64'd0);
    check("post_reset_fwd_en", {63'd0, fwd_en}, 64'd0);

    // Write x5, then reset clears it again.
    apply(0, 1, 1, 5, 0, 32'h0, 32'hDEADBEEF, 5, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5, 0);
    check("x5_written", {32'd0, rs1_data}, 64'hDEADBEEF);
    apply(1, 0, 0, 0, 0, 0, 0, 5, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5, 0);
    check("reset_clears_x5", {32'd0, rs1_data}, 64'h0);
    check("reset_clears_instret", instret, 64'd0);

    // Writeback mux selection.
    apply(0, 1, 1, 3, 1, 32'h11112222, 32'h33334444, 3, 0);
    check("fwd_data_mem", {32'd0, fwd_data}, 64'h11112222);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 3, 0);
    check("mux_sel_mem", {32'd0, rs1_data}, 64'h11112222);
    apply(0, 1, 1, 3, 0, 32'h11112222, 32'h33334444, 3, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 3, 0);
    check("mux_sel_ex", {32'd0, rs1_data}, 64'h33334444);

    // x0 protection: the write is dropped, but the instruction still retires.
    apply(0, 1, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("x0_fwd_en", {63'd0, fwd_en}, 64'd0);
    check("x0_read_same", {32'd0, rs1_data}, 64'h0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_read_after", {32'd0, rs1_data}, 64'h0);
    check("x0_instret", instret, 64'd3);

    // Read during write of x7.
    apply(0, 1, 1, 7, 0, 0, 32'h00000001, 0, 0);
    tick();
    apply(0, 1, 1, 7, 0, 0, 32'h000000AA, 0, 7);
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle", {32'd0, rs2_data}, 64'hAA);
`else
    check("rdw_same_cycle", {32'd0, rs2_data}, 64'h01);
`endif
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 7);
    check("rdw_next_cycle", {32'd0, rs2_data}, 64'hAA);

    // werf_in without wb_valid has no effect.
    apply(0, 0, 1, 9, 0, 0, 32'h5, 9, 0);
    check("novalid_fwd_en", {63'd0, fwd_en}, 64'd0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 9, 0);
    check("novalid_x9", {32'd0, rs1_data}, 64'h0);
    check("novalid_instret", instret, 64'd5);

    // After a reset, 10 retiring non-writes give instret = 10.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 0, 5'(i + 1), 1, 32'hCAFE0000 + i, 32'h0BAD0000 + i, 0, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 5, 7);
    check("count10_instret", instret, 64'd10);
    check("count10_x5", {32'd0, rs1_data}, 64'h0);
    check("count10_x7", {32'd0, rs2_data}, 64'h0);

    // Reset beats a write presented in the same cycle.
    apply(0, 1, 1, 4, 0, 0, 32'h12345678, 0, 0);
    tick();
    apply(1, 1, 1, 4, 0, 0, 32'h87654321, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 4, 0);
    check("reset_wins_x4", {32'd0, rs1_data}, 64'h0);
    check("reset_wins_instret", instret, 64'd0);

    // Randomized traffic, checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      logic [4:0] a1;
      logic [4:0] a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), rd, 1'($urandom),
            $urandom, $urandom, a1, a2);
      tick();
    end

    @(negedge clk);
    done = 1'b1;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value and writes the 32x32 integer register file.
- Serves two combinational decode read ports and a forwarding tap for EX.
- Counts retired instructions.

Parameters:
- XLEN, 32, data width of registers and writeback path.
- NREGS, 32, number of architectural registers (address width = log2(NREGS)).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- wb_valid  input  1  an instruction occupies WB this cycle.
- mem_data_in  input  XLEN  load data from MEM/WB register.
- ex_result_in  input  XLEN  ALU/EX result from MEM/WB register.
- rd_in  input  5  destination register index.
- werf_in  input  1  register-file write enable.
- wb_sel_in  input  1  1 = write mem_data_in, 0 = write ex_result_in.
- rs1_addr  input  5  decode read port 1 address.
- rs2_addr  input  5  decode read port 2 address.
- rs1_data  output  XLEN  read data port 1 (combinational).
- rs2_data  output  XLEN  read data port 2 (combinational).
- fwd_en  output  1  WB holds a valid nonzero-rd write this cycle.
- fwd_rd  output  5  destination of the forwarded value.
- fwd_data  output  XLEN  writeback value for EX forwarding.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Writeback mux (combinational): wb_data = wb_sel_in ? mem_data_in : ex_result_in.
- Write qualifier: we = wb_valid & werf_in & (rd_in != 0).
- Register write:
  - On a rising edge with we=1, regs[rd_in] <= wb_data.
  - Writes to x0 are discarded. x0 reads as 0 always.
- Reads (combinational):
  - rs1_data and rs2_data return regs[addr]; 0 when addr=0.
  - Same-cycle read-during-write bypass is governed by the Optional Feature.
- Forwarding tap:
  - fwd_en = we; fwd_rd = rd_in; fwd_data = wb_data.
  - fwd_rd and fwd_data are driven even when fwd_en=0; consumers qualify on fwd_en.
- Retire counter:
  - instret increments by 1 on each rising edge with wb_valid=1, regardless of werf_in.
  - Wraps from all-ones to 0 with no flag.
- Reset:
  - rst=1 at a rising edge clears every register regs[1..NREGS-1] to 0 and instret to 0.
  - Any write or increment presented in that cycle is dropped; reset wins.
  - Reset asserted mid-stream (rst=1 with wb_valid=1) has the same effect: nothing is written or counted.
- Post-reset outputs:
  - rs1_data and rs2_data = 0 for all addresses.
  - instret = 0.
  - fwd_* follow inputs combinationally (fwd_en=0 while wb_valid=0).
- No enable or stall input: the MEM/WB register owns stalling and must present wb_valid=0 for bubbles.
- Latency: a write presented in cycle N is visible through the array read path from cycle N+1. It is visible via the forwarding tap in cycle N.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If we=1 and rsX_addr == rd_in (nonzero), rsX_data returns wb_data in the same cycle.
  - Write-first semantics; decode needs no separate WB-to-ID forward.
- Undefined:
  - rsX_data returns the pre-write array contents in that cycle (read-old).
  - The new value appears from the next cycle; the hazard unit must cover the 1-cycle gap.
- x0 behaviour is identical in both builds.

Test Plan:
- Reset clears state:
  - Stimulus: write x5=0xDEADBEEF, then pulse rst for 1 cycle.
  - Required response: rs1_addr=5 reads 0x00000000 and instret=0.
- Writeback mux selection:
  - Stimulus: wb_valid=1, werf_in=1, rd_in=3, wb_sel_in=1, mem_data_in=0x11112222, ex_result_in=0x33334444.
  - Required response: next cycle x3=0x11112222.
  - Stimulus: repeat with wb_sel_in=0.
  - Required response: next cycle x3=0x33334444.
- x0 protection:
  - Stimulus: rd_in=0, werf_in=1, wb_valid=1, data 0xFFFFFFFF.
  - Required response: rs1_addr=0 reads 0 and fwd_en=0; instret still increments by 1.
- Read-during-write:
  - Stimulus: x7 holds 0x00000001; write x7=0x000000AA while rs2_addr=7 in the same cycle.
  - Required response with REGFILE_BYPASS_EN: rs2_data=0x000000AA that cycle.
  - Required response without it: rs2_data=0x00000001 that cycle, then 0x000000AA the next cycle.
- Qualification and counting:
  - Stimulus: werf_in=1 with wb_valid=0 for rd=9, data 0x5.
  - Required response: x9 unchanged and instret unchanged.
  - Stimulus: 10 cycles of wb_valid=1 with werf_in=0.
  - Required response: instret=10 and no register changes.
- Reset wins over write:
  - Stimulus: rst=1 and we=1 to x4 in the same cycle.
  - Required response: x4=0 and instret=0 afterward.
